// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial sensor SPI front end.
// Holds the sequencer and SPI state encodings, the sensor configuration
// words, the read addresses, and a helper that maps a sequencer state to
// the SPI command that state issues.
package inert_pkg;

  localparam int INIT_WAIT_DEF = 65536;
  localparam int SCLK_DIV_DEF  = 32;

  typedef enum logic [3:0] {
    INIT_WT, CFG0, CFG1, CFG2, CFG3, WAIT_INT,
    RD_PL, RD_PH, RD_AL, RD_AH, UPD
  } inert_st_t;

  typedef enum logic [1:0] {SPI_IDLE, SPI_SHIFT, SPI_BP} spi_st_t;

  localparam logic [15:0] CFG0_CMD = 16'h0D02;  // INT on gyro data ready
  localparam logic [15:0] CFG1_CMD = 16'h1053;  // accel 208Hz
  localparam logic [15:0] CFG2_CMD = 16'h1150;  // gyro 208Hz
  localparam logic [15:0] CFG3_CMD = 16'h1460;  // rounding on

  localparam logic [7:0] RD_PL_ADDR = 8'hA2;
  localparam logic [7:0] RD_PH_ADDR = 8'hA3;
  localparam logic [7:0] RD_AL_ADDR = 8'hAC;
  localparam logic [7:0] RD_AH_ADDR = 8'hAD;

  // Command launched on entry to state s; read commands carry a zero data byte.
  function automatic logic [15:0] st_cmd(inert_st_t s);
    case (s)
      CFG0:    st_cmd = CFG0_CMD;
      CFG1:    st_cmd = CFG1_CMD;
      CFG2:    st_cmd = CFG2_CMD;
      CFG3:    st_cmd = CFG3_CMD;
      RD_PL:   st_cmd = {RD_PL_ADDR, 8'h00};
      RD_PH:   st_cmd = {RD_PH_ADDR, 8'h00};
      RD_AL:   st_cmd = {RD_AL_ADDR, 8'h00};
      RD_AH:   st_cmd = {RD_AH_ADDR, 8'h00};
      default: st_cmd = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/spi_mnrch.sv
// SPI master for one 16-bit transaction, MSB first, SCLK idling high.
// Ports: clk/rst (sync, active high); wrt starts a transfer of cmd;
// done pulses one cycle as SS_n rises; rd_data holds the 16 bits sampled
// on MISO; SS_n/SCLK/MOSI drive the sensor.
module spi_mnrch import inert_pkg::*; #(
  parameter int SCLK_DIV = SCLK_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int DW   = $clog2(HALF);

  spi_st_t        st_q, st_d;
  logic [DW-1:0]  div_q, div_d;
  logic [3:0]     bit_q, bit_d;
  logic           first_q, first_d;
  logic [15:0]    tx_q, tx_d;
  logic [15:0]    rx_q, rx_d;
  logic           sclk_q, sclk_d;
  logic           ss_n_q, ss_n_d;
  logic           done_q, done_d;
  logic           tick;

  assign tick = (div_q == DW'(HALF - 1));

  always_comb begin
    st_d    = st_q;
    div_d   = div_q;
    bit_d   = bit_q;
    first_d = first_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    ss_n_d  = ss_n_q;
    done_d  = 1'b0;
    case (st_q)
      SPI_IDLE: if (wrt) begin
        st_d    = SPI_SHIFT;
        ss_n_d  = 1'b0;
        tx_d    = cmd;        // MSB is on MOSI from the SS_n fall
        div_d   = '0;
        bit_d   = '0;
        first_d = 1'b1;
        sclk_d  = 1'b1;
      end
      SPI_SHIFT: begin
        div_d = div_q + DW'(1);
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            // Falling edge: advance MOSI, except the first fall where
            // bit 15 is already presented.
            first_d = 1'b0;
            if (!first_q) tx_d = {tx_q[14:0], 1'b0};
          end else begin
            rx_d  = {rx_q[14:0], MISO};
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd15) st_d = SPI_BP;  // SCLK stays high from here
          end
        end
      end
      SPI_BP: begin
        div_d = div_q + DW'(1);
        if (tick) begin
          st_d   = SPI_IDLE;
          ss_n_d = 1'b1;
          done_d = 1'b1;
          tx_d   = '0;
          div_d  = '0;
        end
      end
      default: st_d = SPI_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= SPI_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      first_q <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b1;
      ss_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      first_q <= first_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      ss_n_q  <= ss_n_d;
      done_q  <= done_d;
    end
  end

  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_q;
  assign MOSI    = tx_q[15];
  assign done    = done_q;
  assign rd_data = rx_q;

endmodule

// File: rtl/inert_intf.sv
// Inertial sensor front end: configures the sensor after power-up, then on
// each data-ready interrupt reads pitch rate and Z accel and publishes both.
// Ports: clk/rst (sync, active high); INT async data ready; MISO/SS_n/SCLK/
// MOSI SPI link; ptch_rt/AZ signed 16-bit samples; vld one-cycle update pulse.
module inert_intf import inert_pkg::*; #(
  parameter int INIT_WAIT = INIT_WAIT_DEF,
  parameter int SCLK_DIV  = SCLK_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld
);

  localparam int CW = $clog2(INIT_WAIT + 1);

  inert_st_t   st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  pl_q, pl_d, ph_q, ph_d, al_q, al_d, ah_q, ah_d;
  logic [15:0] ptch_q, ptch_d, az_q, az_d;
  logic        vld_q, vld_d;
  logic        int_meta_q, int_sync_q;
  logic        wrt, done;
  logic [15:0] cmd, rd_data;
  logic        unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];

  spi_mnrch #(.SCLK_DIV(SCLK_DIV)) u_spi (
    .clk(clk), .rst(rst), .wrt(wrt), .cmd(cmd), .done(done),
    .rd_data(rd_data), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    pl_d   = pl_q;
    ph_d   = ph_q;
    al_d   = al_q;
    ah_d   = ah_q;
    ptch_d = ptch_q;
    az_d   = az_q;
    vld_d  = 1'b0;
    wrt    = 1'b0;
    case (st_q)
      INIT_WT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(INIT_WAIT - 1)) begin st_d = CFG0; wrt = 1'b1; end
      end
      CFG0: if (done) begin st_d = CFG1; wrt = 1'b1; end
      CFG1: if (done) begin st_d = CFG2; wrt = 1'b1; end
      CFG2: if (done) begin st_d = CFG3; wrt = 1'b1; end
      CFG3: if (done) st_d = WAIT_INT;
      // Level sensitive: an INT still high here starts the next set at once.
      WAIT_INT: if (int_sync_q) begin st_d = RD_PL; wrt = 1'b1; end
      RD_PL: if (done) begin pl_d = rd_data[7:0]; st_d = RD_PH; wrt = 1'b1; end
      RD_PH: if (done) begin ph_d = rd_data[7:0]; st_d = RD_AL; wrt = 1'b1; end
      RD_AL: if (done) begin al_d = rd_data[7:0]; st_d = RD_AH; wrt = 1'b1; end
      RD_AH: if (done) begin ah_d = rd_data[7:0]; st_d = UPD; end
      // Both words move together from the holding regs so a pair is never torn.
      UPD: begin
        ptch_d = {ph_q, pl_q};
        az_d   = {ah_q, al_q};
        vld_d  = 1'b1;
        st_d   = WAIT_INT;
      end
      default: st_d = INIT_WT;
    endcase
  end

  assign cmd = st_cmd(st_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= INIT_WT;
      cnt_q      <= '0;
      pl_q       <= '0;
      ph_q       <= '0;
      al_q       <= '0;
      ah_q       <= '0;
      ptch_q     <= '0;
      az_q       <= '0;
      vld_q      <= 1'b0;
      int_meta_q <= 1'b0;
      int_sync_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      pl_q       <= pl_d;
      ph_q       <= ph_d;
      al_q       <= al_d;
      ah_q       <= ah_d;
      ptch_q     <= ptch_d;
      az_q       <= az_d;
      vld_q      <= vld_d;
      int_meta_q <= INT;
      int_sync_q <= int_meta_q;
    end
  end

  assign ptch_rt = ptch_q;
  assign AZ      = az_q;
  assign vld     = vld_q;

endmodule
